// File: rtl/controller_event_queue.sv
// Genesis pad front end: per-button debounce, D-pad auto-repeat, game-state gating,
// fixed-priority arbitration into a 4-deep command FIFO drained by valid/ready.
module controller_event_queue #(
    parameter logic [2:0]  CARREGANDO      = 3'b010,
    parameter logic [2:0]  VITORIA         = 3'b101,
    parameter logic [2:0]  DERROTA         = 3'b110,
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic        clk,
    input  logic        reset_fixed,
    input  logic [11:0] buttons,
    input  logic [2:0]  game_state,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [3:0]  cmd_code,
    output logic [11:0] pressed,
    output logic [2:0]  fifo_level
);

    localparam logic [15:0] DEB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

    // Arbitration order, highest priority first.
    localparam logic [3:0] PRIO [12] = '{4'd1, 4'd0, 4'd7, 4'd6, 4'd5, 4'd4,
                                         4'd3, 4'd2, 4'd11, 4'd10, 4'd9, 4'd8};

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_PERIOD} repState_t;

    logic [15:0] dbCnt_q [12];
    logic [11:0] deb_q;
    logic [11:0] flip;
    logic [11:0] pressEv;
    logic [3:0]  dirRel;

    repState_t   repState_q;
    logic [1:0]  repIdx_q;
    logic [23:0] repTimer_q;
    logic        dirPress;
    logic [1:0]  newIdx;
    logic        repRelease;
    logic        timerHit;
    logic        repFire;
    logic [11:0] repEv;

    logic        gated;
    logic [11:0] eventMask;
    logic [11:0] pend_q, pend_d;
    logic        grantValid;
    logic [3:0]  grantIdx;
    logic        pop, push, canPush;

    logic [3:0]  fifoMem_q [4];
    logic [1:0]  wrPtr_q, rdPtr_q;
    logic [2:0]  level_q, level_d;

    always_ff @(posedge clk or negedge reset_fixed) begin
        if (!reset_fixed) begin
            deb_q <= '0;
            for (int i = 0; i < 12; i++) dbCnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (buttons[i] != deb_q[i]) begin
                    if (dbCnt_q[i] == DEB_LAST) begin
                        deb_q[i]   <= ~deb_q[i];
                        dbCnt_q[i] <= '0;
                    end else begin
                        dbCnt_q[i] <= dbCnt_q[i] + 16'd1;
                    end
                end else begin
                    dbCnt_q[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        flip = '0;
        for (int i = 0; i < 12; i++)
            flip[i] = (buttons[i] != deb_q[i]) && (dbCnt_q[i] == DEB_LAST);
        pressEv = flip & buttons;
        dirRel  = flip[11:8] & ~buttons[11:8];
    end

    always_comb begin
        dirPress = |pressEv[11:8];
        newIdx   = repIdx_q;
        for (int d = 0; d < 4; d++)
            if (pressEv[8 + d]) newIdx = 2'(d);
        repRelease = dirRel[repIdx_q];
        timerHit   = ((repState_q == R_DELAY)  && (repTimer_q == DELAY_LAST)) ||
                     ((repState_q == R_PERIOD) && (repTimer_q == PERIOD_LAST));
        // A new press or a release of the repeating direction pre-empts a repeat.
        repFire    = timerHit && !dirPress && !repRelease;
        repEv      = repFire ? (12'h100 << repIdx_q) : 12'h000;
    end

    always_ff @(posedge clk or negedge reset_fixed) begin
        if (!reset_fixed) begin
            repState_q <= R_IDLE;
            repIdx_q   <= '0;
            repTimer_q <= '0;
        end else if (dirPress) begin
            repState_q <= R_DELAY;
            repIdx_q   <= newIdx;
            repTimer_q <= '0;
        end else if (repState_q != R_IDLE && repRelease) begin
            repState_q <= R_IDLE;
            repTimer_q <= '0;
        end else begin
            case (repState_q)
                R_DELAY: begin
                    if (timerHit) begin
                        repState_q <= R_PERIOD;
                        repTimer_q <= '0;
                    end else begin
                        repTimer_q <= repTimer_q + 24'd1;
                    end
                end
                R_PERIOD: begin
                    if (timerHit) repTimer_q <= '0;
                    else          repTimer_q <= repTimer_q + 24'd1;
                end
                default: repTimer_q <= '0;
            endcase
        end
    end

    always_comb begin
        gated     = (game_state == CARREGANDO) || (game_state == VITORIA) ||
                    (game_state == DERROTA);
        eventMask = gated ? 12'h002 : 12'hFFF;

        grantValid = 1'b0;
        grantIdx   = '0;
        for (int k = 11; k >= 0; k--) begin
            if (pend_q[PRIO[k]]) begin
                grantValid = 1'b1;
                grantIdx   = PRIO[k];
            end
        end

        pop     = cmd_valid && cmd_ready;
        canPush = (level_q != 3'd4) || pop;
        push    = grantValid && canPush;

        pend_d = pend_q;
        if (push) pend_d[grantIdx] = 1'b0;
        pend_d = pend_d | ((pressEv | repEv) & eventMask);

        case ({push, pop})
            2'b10:   level_d = level_q + 3'd1;
            2'b01:   level_d = level_q - 3'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_fixed) begin
        if (!reset_fixed) begin
            pend_q  <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
            for (int j = 0; j < 4; j++) fifoMem_q[j] <= '0;
        end else begin
            pend_q  <= pend_d;
            level_q <= level_d;
            if (push) begin
                fifoMem_q[wrPtr_q] <= grantIdx;
                wrPtr_q            <= wrPtr_q + 2'd1;
            end
            if (pop) rdPtr_q <= rdPtr_q + 2'd1;
        end
    end

    assign cmd_valid  = (level_q != 3'd0);
    assign cmd_code   = fifoMem_q[rdPtr_q];
    assign pressed    = deb_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_controller_event_queue.sv
// Bench for controller_event_queue: directed vector table, hand-written corner
// sequences and a randomized run, all shadowed by a cycle-level reference model.
module tb_controller_event_queue;

    localparam int DEB    = 4;
    localparam int DELAY  = 20;
    localparam int PERIOD = 8;
    localparam int PRIO [12] = '{1, 0, 7, 6, 5, 4, 3, 2, 11, 10, 9, 8};

    logic        clk = 1'b0;
    logic        reset_fixed = 1'b0;
    logic [11:0] buttons = '0;
    logic [2:0]  game_state = '0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic [11:0] pressed;
    logic [2:0]  fifo_level;

    int checks = 0;
    int failures = 0;

    controller_event_queue #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(DELAY),
        .REPEAT_PERIOD(PERIOD)
    ) dut (
        .clk(clk),
        .reset_fixed(reset_fixed),
        .buttons(buttons),
        .game_state(game_state),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .pressed(pressed),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model: debounced vector, consecutive-differ counts, pending set,
    // command queue and the repeating direction with the edge of its press.
    bit [11:0] mDeb;
    int        mCnt [12];
    bit [11:0] mPend;
    int        mQ [$];
    int        mRepDir;
    longint    mPressT;
    longint    mEdge;

    task automatic resetModel();
        mDeb = '0;
        for (int i = 0; i < 12; i++) mCnt[i] = 0;
        mPend = '0;
        mQ.delete();
        mRepDir = -1;
        mPressT = 0;
        mEdge = 0;
    endtask

    task automatic modelStep();
        bit        popNow;
        bit        doPush;
        int        g;
        bit [11:0] pressEv;
        bit [11:0] relEv;
        bit [11:0] repEv;
        bit [11:0] mask;
        bit        dirPress;
        bit        isGated;
        longint    e;
        popNow = (mQ.size() > 0) && cmd_ready;
        g = -1;
        for (int k = 0; k < 12; k++)
            if (g < 0 && mPend[PRIO[k]]) g = PRIO[k];
        doPush = (g >= 0) && ((mQ.size() < 4) || popNow);
        pressEv = '0;
        relEv = '0;
        for (int i = 0; i < 12; i++) begin
            if (buttons[i] != mDeb[i]) begin
                mCnt[i]++;
                if (mCnt[i] == DEB) begin
                    mDeb[i] = ~mDeb[i];
                    mCnt[i] = 0;
                    if (mDeb[i]) pressEv[i] = 1'b1;
                    else         relEv[i] = 1'b1;
                end
            end else begin
                mCnt[i] = 0;
            end
        end
        repEv = '0;
        dirPress = |pressEv[11:8];
        if (mRepDir >= 0 && relEv[mRepDir]) mRepDir = -1;
        if (!dirPress && mRepDir >= 0) begin
            e = mEdge - mPressT;
            if (e >= DELAY && ((e - DELAY) % PERIOD) == 0) repEv[mRepDir] = 1'b1;
        end
        if (dirPress) begin
            for (int d = 8; d < 12; d++)
                if (pressEv[d]) mRepDir = d;
            mPressT = mEdge;
        end
        isGated = (game_state == 3'b010) || (game_state == 3'b101) || (game_state == 3'b110);
        mask = isGated ? 12'h002 : 12'hFFF;
        if (doPush) mPend[g] = 1'b0;
        mPend = mPend | ((pressEv | repEv) & mask);
        if (popNow) void'(mQ.pop_front());
        if (doPush) mQ.push_back(g);
        mEdge++;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("modelValid", 16'(cmd_valid), 16'(mQ.size() != 0));
        checkOutput("modelLevel", 16'(fifo_level), 16'(mQ.size()));
        checkOutput("modelPressed", 16'(pressed), 16'(mDeb));
        if (mQ.size() != 0) checkOutput("modelCode", 16'(cmd_code), 16'(mQ[0]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_fixed) modelStep();
        #1;
        compareModel();
    endtask

    task automatic applyStimulus(input logic [11:0] b, input logic [2:0] gs, input logic rdy);
        buttons = b;
        game_state = gs;
        cmd_ready = rdy;
    endtask

    typedef struct {
        logic [11:0] btn;
        logic [2:0]  gs;
        logic        rdy;
        int          ticks;
        logic [11:0] expPressed;
        logic [2:0]  expLevel;
        logic [3:0]  expCode;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int  seen [$];
        int  seenCode [$];
        int  expDrain [6];
        int  expRep [6];
        bit  timedOut;

        vecs = '{
            '{12'h000, 3'd0, 1'b0, 3,  12'h000, 3'd0, 4'd0},
            '{12'h080, 3'd0, 1'b0, 3,  12'h000, 3'd0, 4'd0},
            '{12'h080, 3'd0, 1'b0, 1,  12'h080, 3'd0, 4'd0},
            '{12'h080, 3'd0, 1'b0, 1,  12'h080, 3'd1, 4'd7},
            '{12'h080, 3'd0, 1'b1, 1,  12'h080, 3'd0, 4'd0},
            '{12'h000, 3'd0, 1'b0, 3,  12'h080, 3'd0, 4'd0},
            '{12'h000, 3'd0, 1'b0, 1,  12'h000, 3'd0, 4'd0},
            '{12'h008, 3'd0, 1'b0, 3,  12'h000, 3'd0, 4'd0},
            '{12'h000, 3'd0, 1'b0, 6,  12'h000, 3'd0, 4'd0},
            '{12'h882, 3'd0, 1'b0, 4,  12'h882, 3'd0, 4'd0},
            '{12'h882, 3'd0, 1'b0, 1,  12'h882, 3'd1, 4'd1},
            '{12'h882, 3'd0, 1'b0, 1,  12'h882, 3'd2, 4'd1},
            '{12'h882, 3'd0, 1'b0, 1,  12'h882, 3'd3, 4'd1},
            '{12'h882, 3'd0, 1'b1, 1,  12'h882, 3'd2, 4'd7},
            '{12'h882, 3'd0, 1'b1, 1,  12'h882, 3'd1, 4'd11},
            '{12'h882, 3'd0, 1'b1, 1,  12'h882, 3'd0, 4'd0},
            '{12'h000, 3'd0, 1'b0, 4,  12'h000, 3'd0, 4'd0},
            '{12'h000, 3'd0, 1'b0, 20, 12'h000, 3'd0, 4'd0},
            '{12'h102, 3'd5, 1'b0, 5,  12'h102, 3'd1, 4'd1},
            '{12'h102, 3'd5, 1'b0, 25, 12'h102, 3'd1, 4'd1},
            '{12'h000, 3'd5, 1'b1, 4,  12'h000, 3'd0, 4'd0},
            '{12'h000, 3'd0, 1'b0, 10, 12'h000, 3'd0, 4'd0},
            '{12'h07D, 3'd0, 1'b0, 4,  12'h07D, 3'd0, 4'd0},
            '{12'h07D, 3'd0, 1'b0, 4,  12'h07D, 3'd4, 4'd0},
            '{12'h07D, 3'd0, 1'b0, 6,  12'h07D, 3'd4, 4'd0}
        };
        expDrain = '{0, 6, 5, 4, 3, 2};
        expRep   = '{5, 25, 33, 41, 49, 57};

        resetModel();
        applyStimulus(12'h000, 3'd0, 1'b0);
        #22;
        checkOutput("resetValid", 16'(cmd_valid), 16'd0);
        checkOutput("resetCode", 16'(cmd_code), 16'd0);
        checkOutput("resetPressed", 16'(pressed), 16'd0);
        checkOutput("resetLevel", 16'(fifo_level), 16'd0);
        reset_fixed = 1'b1;

        foreach (vecs[v]) begin
            applyStimulus(vecs[v].btn, vecs[v].gs, vecs[v].rdy);
            for (int t = 0; t < vecs[v].ticks; t++) tick();
            checkOutput($sformatf("vec%0dPressed", v), 16'(pressed), 16'(vecs[v].expPressed));
            checkOutput($sformatf("vec%0dLevel", v), 16'(fifo_level), 16'(vecs[v].expLevel));
            checkOutput($sformatf("vec%0dValid", v), 16'(cmd_valid), 16'(vecs[v].expLevel != 0));
            if (vecs[v].expLevel != 0)
                checkOutput($sformatf("vec%0dCode", v), 16'(cmd_code), 16'(vecs[v].expCode));
        end

        // Drain the saturated FIFO plus the two held pending bits in priority order.
        applyStimulus(12'h07D, 3'd0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("drainValid%0d", k), 16'(cmd_valid), 16'd1);
            checkOutput($sformatf("drainCode%0d", k), 16'(cmd_code), 16'(expDrain[k]));
            tick();
        end
        checkOutput("drainLevel", 16'(fifo_level), 16'd0);
        applyStimulus(12'h000, 3'd0, 1'b0);
        for (int t = 0; t < 4; t++) tick();
        checkOutput("drainRelease", 16'(pressed), 16'd0);

        // Left held: press command then repeats; release lands on a repeat slot.
        cmd_ready = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            buttons = (t <= 60) ? 12'h200 : 12'h000;
            tick();
            if (cmd_valid) begin
                seen.push_back(t);
                seenCode.push_back(int'(cmd_code));
            end
        end
        checkOutput("repeatCount", 16'(seen.size()), 16'd6);
        for (int k = 0; k < 6 && k < seen.size(); k++) begin
            checkOutput($sformatf("repeatTick%0d", k), 16'(seen[k]), 16'(expRep[k]));
            checkOutput($sformatf("repeatCode%0d", k), 16'(seenCode[k]), 16'd9);
        end

        // Reset with two entries queued, then a held button re-presses.
        applyStimulus(12'h003, 3'd0, 1'b0);
        for (int t = 0; t < 6; t++) tick();
        checkOutput("preResetLevel", 16'(fifo_level), 16'd2);
        checkOutput("preResetCode", 16'(cmd_code), 16'd1);
        #2;
        reset_fixed = 1'b0;
        #1;
        resetModel();
        checkOutput("midResetValid", 16'(cmd_valid), 16'd0);
        checkOutput("midResetCode", 16'(cmd_code), 16'd0);
        checkOutput("midResetPressed", 16'(pressed), 16'd0);
        checkOutput("midResetLevel", 16'(fifo_level), 16'd0);
        for (int t = 0; t < 3; t++) tick();
        #2;
        reset_fixed = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        checkOutput("rePressEarly", 16'(pressed), 16'd0);
        tick();
        checkOutput("rePressed", 16'(pressed), 16'h003);
        tick();
        checkOutput("rePressLevel", 16'(fifo_level), 16'd1);
        checkOutput("rePressCode", 16'(cmd_code), 16'd1);

        // Randomized run against the model.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 11) == 0) buttons[i] = ~buttons[i];
            for (int i = 8; i < 12; i++)
                if ($urandom_range(0, 39) == 0) buttons[i] = ~buttons[i];
            if ($urandom_range(0, 49) == 0) game_state = 3'($urandom_range(0, 7));
            cmd_ready = ($urandom_range(0, 3) == 0);
            if (c == 2000) begin
                reset_fixed = 1'b0;
                #1;
                resetModel();
                checkOutput("randResetLevel", 16'(fifo_level), 16'd0);
                #1;
                reset_fixed = 1'b1;
            end
            tick();
        end

        // Final drain with a bounded wait.
        applyStimulus(12'h000, 3'd0, 1'b1);
        timedOut = 1'b1;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (!cmd_valid && mQ.size() == 0 && pressed == 12'h000) begin
                timedOut = 1'b0;
                break;
            end
        end
        checkOutput("finalDrainTimeout", 16'(timedOut), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controller_event_queue.md
# controller_event_queue

Turns the 12-bit button vector from the Genesis pad reader into a stream of discrete button commands for the sudoku game FSM. Each button is debounced and press-edge detected, and the D-pad gets auto-repeat. Simultaneous events are arbitrated by fixed priority into a 4-deep command FIFO, which is drained over a valid/ready handshake. Events are gated by game state, so only START is accepted outside active play.

## Interface
- `CARREGANDO`, 3'b010, game_state encoding for the loading state.
- `VITORIA`, 3'b101, game_state encoding for the victory state.
- `DERROTA`, 3'b110, game_state encoding for the defeat state.
- `DEBOUNCE_CYCLES`, 20000, consecutive cycles a raw bit must differ from its debounced value before the debounced value flips; legal range 1 to 2^16-1.
- `REPEAT_DELAY`, 12500000, held cycles before the first D-pad repeat; legal range 1 to 2^24-1.
- `REPEAT_PERIOD`, 5000000, cycles between subsequent D-pad repeats; legal range 1 to 2^24-1.
- `clk`, input, 1, system clock; all logic on the rising edge.
- `reset_fixed`, input, 1, asynchronous, active-low reset.
- `buttons`, input, 12, active-high pressed bits from the pad reader.
  - Bit order {up, down, left, right, a, b, c, x, y, z, start, mode}, so bit 11 = up and bit 0 = mode.
  - Already synchronous to clk.
- `game_state`, input, 3, current game FSM state.
- `cmd_ready`, input, 1, consumer accepts the FIFO head this cycle.
- `cmd_valid`, output, 1, FIFO non-empty.
- `cmd_code`, output, 4, button index 0..11 at the FIFO head (index = bit position in `buttons`).
- `pressed`, output, 12, debounced button vector.
- `fifo_level`, output, 3, number of queued commands, 0..4.

## Operation
- **Debounce (per bit)**
  - A 16-bit counter increments on each edge where raw differs from debounced; it clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and raw still differs, the debounced bit flips and the counter clears.
  - A 0→1 flip is a press event; 1→0 flips produce no event.
- **Gating**
  - When game_state is CARREGANDO, VITORIA or DERROTA, press and repeat events for every bit except start (bit 1) are discarded.
  - Gating is evaluated at event time. Entries already queued are still delivered.
- **Pending register (12 bits)**
  - An accepted event sets its pending bit.
  - A second event on an already-pending bit coalesces into it; no count is kept.
- **Arbiter**
  - Each cycle, if the FIFO is not full, the highest-priority pending bit is written to the FIFO and cleared.
  - Priority, highest first: start(1), mode(0), a(7), b(6), c(5), x(4), y(3), z(2), up(11), down(10), left(9), right(8).
  - One write per cycle. If a bit is cleared and set in the same cycle, set wins.
- **FIFO**
  - Depth 4. `cmd_code` is the head, read combinationally from storage registers.
  - Pop occurs when `cmd_valid && cmd_ready`.
  - Simultaneous push and pop on a full FIFO is allowed: the arbiter treats the FIFO as not-full when a pop occurs that cycle, and the level stays 4.
  - Push into an empty FIFO with `cmd_ready` high: the entry is popped no earlier than the cycle after it appears.
- **Auto-repeat FSM**
  - States: R_IDLE, R_DELAY, R_PERIOD.
  - Registers: `rep_idx` (2-bit direction) and a 24-bit timer.
  - A press event on any direction, gated or not, loads `rep_idx`, clears the timer and enters R_DELAY. The most recent press wins.
  - R_DELAY: the timer increments each cycle. At REPEAT_DELAY-1 it emits a repeat event for `rep_idx` (subject to gating), clears the timer and enters R_PERIOD.
  - R_PERIOD: same behaviour at REPEAT_PERIOD-1; stays in R_PERIOD.
  - Debounced release of `rep_idx` in any state returns to R_IDLE, with no event that cycle.
  - Non-direction buttons never repeat.

## Timing
- **Reset values:** `cmd_valid`=0, `cmd_code`=0, `pressed`=0, `fifo_level`=0. Pending, counters and FIFO pointers are cleared and the repeat FSM is in R_IDLE.
- **Reset mid-operation:** the queue is lost. A button still held at release of reset produces a fresh press after DEBOUNCE_CYCLES.
- **Press latency:**
  - Raw first sampled high at edge E.
  - `pressed` bit and pending bit set at edge E+DEBOUNCE_CYCLES-1.
  - FIFO write at edge E+DEBOUNCE_CYCLES, so `cmd_valid` is high after that edge if the FIFO was empty and no higher-priority bit was pending.
- **Repeat latency:** first repeat pending set REPEAT_DELAY edges after the press-event edge; subsequent repeats every REPEAT_PERIOD edges.
- **Glitch rejection:** a raw pulse shorter than DEBOUNCE_CYCLES never changes `pressed`.

## Test plan
With DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 and game_state=3'b000 unless stated:
- **Single press:** A (bit 7) raw high from edge 10 → `pressed[7]` set at edge 13; `cmd_valid`=1 with `cmd_code`=7 after edge 14; pop with `cmd_ready` → `fifo_level`=0.
- **Glitch:** a 3-cycle raw pulse on bit 3 → no `pressed` change, `cmd_valid` stays 0.
- **Arbitration:** up, a and start rise on the same edge with `cmd_ready`=0 → FIFO order 1, 7, 11 on consecutive edges; `fifo_level`=3.
- **Full FIFO:** `cmd_ready`=0 and 6 distinct buttons pressed → `fifo_level` saturates at 4 and 2 pending bits are held. Raising `cmd_ready` drains all 6 commands in priority order with none lost.
- **Auto-repeat:** left held 60 cycles past debounce → code 9 at press, then at +20, +28, +36, +44, +52. Release returns the FSM to R_IDLE with no further codes.
- **Gating and reset:**
  - game_state=3'b101 with right and start pressed → only code 1 is queued.
  - Asserting `reset_fixed`=0 with 2 entries queued → all outputs read 0 immediately.
